// File: rtl/debounce_multi.sv
// debounce_multi
// Multi-channel switch/push-button debouncer. Each channel optionally passes
// through a flip-flop synchroniser, then a stability counter decides when the
// sampled level has disagreed with the clean level long enough to be accepted.
// In fast-attack mode (MODE=1) a rising sample is accepted immediately while
// falling edges are still qualified.
//
// Ports:
//   clk    - system clock, all state updates on the rising edge
//   reset  - synchronous, active-high reset (clears every flop)
//   b      - raw bouncy inputs, one bit per channel
//   s      - registered debounced level per channel
//   rise   - one-cycle pulse, registered, when s[i] goes 0->1
//   fall   - one-cycle pulse, registered, when s[i] goes 1->0
module debounce_multi #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 3,
  parameter int MODE          = 0,
  parameter int SYNC_STAGES   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] b,
  output logic [CHANNELS-1:0] s,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  // Last count value before a differing sample is accepted.
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [CHANNELS-1:0]         x_s;
  logic [CHANNELS-1:0]         s_q, s_d;
  logic [CHANNELS-1:0]         rise_q, rise_d;
  logic [CHANNELS-1:0]         fall_q, fall_d;
  logic [CHANNELS-1:0][CW-1:0] cnt_q, cnt_d;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign x_s = b;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;

      // Synchroniser shift chain; stage 0 captures the raw input.
      always_ff @(posedge clk) begin
        if (reset) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= b;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
          end
        end
      end

      assign x_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Per-channel filter decision: next clean level, counter and edge pulses.
  always_comb begin
    s_d    = s_q;
    cnt_d  = cnt_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (x_s[i] == s_q[i]) begin
        // Any agreeing sample restarts qualification.
        cnt_d[i] = '0;
      end else if ((MODE == 1) && !s_q[i]) begin
        // Fast attack: first high sample is taken at once.
        s_d[i]    = 1'b1;
        cnt_d[i]  = '0;
        rise_d[i] = 1'b1;
      end else if (cnt_q[i] == CNT_MAX) begin
        s_d[i]    = x_s[i];
        cnt_d[i]  = '0;
        rise_d[i] = x_s[i];
        fall_d[i] = ~x_s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q    <= '0;
      rise_q <= '0;
      fall_q <= '0;
      cnt_q  <= '0;
    end else begin
      s_q    <= s_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign s    = s_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: three instances (symmetric, fast-attack,
// symmetric with a two-stage synchroniser) share clock and reset. Stimulus
// pushes the expected post-edge outputs, tagged with the edge number, into a
// queue; an independent monitor pops and compares after each rising edge.
module tb_debounce_multi;

  logic       clk;
  logic       reset;
  logic [3:0] b0, b1, b2;
  logic [3:0] s0, r0, f0;
  logic [3:0] s1, r1, f1;
  logic [3:0] s2, r2, f2;

  int checks;
  int errors;
  int edge_n;

  typedef struct packed {
    logic [31:0] edge_no;
    logic [1:0]  inst;
    logic [11:0] srf;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  debounce_multi #(.CHANNELS(4), .STABLE_CYCLES(3), .MODE(0), .SYNC_STAGES(0)) u_sym (
    .clk(clk), .reset(reset), .b(b0), .s(s0), .rise(r0), .fall(f0));

  debounce_multi #(.CHANNELS(4), .STABLE_CYCLES(3), .MODE(1), .SYNC_STAGES(0)) u_fa (
    .clk(clk), .reset(reset), .b(b1), .s(s1), .rise(r1), .fall(f1));

  debounce_multi #(.CHANNELS(4), .STABLE_CYCLES(3), .MODE(0), .SYNC_STAGES(2)) u_sync (
    .clk(clk), .reset(reset), .b(b2), .s(s2), .rise(r2), .fall(f2));

  // Period 60: rising edges at t=30, 90, 150, ...
  initial begin
    clk = 1'b0;
    forever #30 clk = ~clk;
  end

  // Queue an expectation for the next rising edge.
  task automatic push_exp(input int inst, input logic [3:0] s_e, input logic [3:0] r_e,
                          input logic [3:0] f_e, input string nm);
    exp_t e;
    e.edge_no = 32'(edge_n + 1);
    e.inst    = 2'(inst);
    e.srf     = {s_e, r_e, f_e};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Drive all inputs at the falling edge.
  task automatic step(input logic rst, input logic [3:0] v0, input logic [3:0] v1,
                      input logic [3:0] v2);
    @(negedge clk);
    reset = rst;
    b0    = v0;
    b1    = v1;
    b2    = v2;
  endtask

  // Monitor: after each rising edge, check every expectation due for it.
  initial begin
    exp_t        e;
    string       nm;
    logic [11:0] act;
    edge_n = 0;
    forever begin
      @(posedge clk);
      edge_n = edge_n + 1;
      #1;
      while (exp_q.size() > 0 && int'(exp_q[0].edge_no) <= edge_n) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        case (e.inst)
          2'd0:    act = {s0, r0, f0};
          2'd1:    act = {s1, r1, f1};
          default: act = {s2, r2, f2};
        endcase
        checks = checks + 1;
        if (int'(e.edge_no) != edge_n || act !== e.srf) begin
          errors = errors + 1;
          $display("FAIL %s edge %0d inst %0d: got s=%b rise=%b fall=%b, want s=%b rise=%b fall=%b (due edge %0d)",
                   nm, edge_n, e.inst, act[11:8], act[7:4], act[3:0],
                   e.srf[11:8], e.srf[7:4], e.srf[3:0], e.edge_no);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by t=200000, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] gl;
    logic [3:0] pat;
    logic       v;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    b0     = 4'b1111;
    b1     = 4'b1111;
    b2     = 4'b1111;

    // Reset holds everything low even with inputs high.
    repeat (2) begin
      step(1'b1, 4'b1111, 4'b1111, 4'b1111);
      push_exp(0, 4'b0000, 4'b0000, 4'b0000, "rst_sym");
      push_exp(1, 4'b0000, 4'b0000, 4'b0000, "rst_fa");
      push_exp(2, 4'b0000, 4'b0000, 4'b0000, "rst_sync");
    end

    // Release: symmetric rises on 3rd edge, synchronised copy 2 edges later.
    step(1'b0, 4'b1111, 4'b0000, 4'b1111);
    push_exp(0, 4'b0000, 4'b0000, 4'b0000, "rel_c1");
    push_exp(1, 4'b0000, 4'b0000, 4'b0000, "fa_idle");
    push_exp(2, 4'b0000, 4'b0000, 4'b0000, "sync_c1");
    step(1'b0, 4'b1111, 4'b0000, 4'b1111);
    push_exp(0, 4'b0000, 4'b0000, 4'b0000, "rel_c2");
    push_exp(2, 4'b0000, 4'b0000, 4'b0000, "sync_c2");
    step(1'b0, 4'b1111, 4'b0000, 4'b1111);
    push_exp(0, 4'b1111, 4'b1111, 4'b0000, "rel_rise");
    push_exp(2, 4'b0000, 4'b0000, 4'b0000, "sync_c3");
    step(1'b0, 4'b1111, 4'b0000, 4'b1111);
    push_exp(0, 4'b1111, 4'b0000, 4'b0000, "rel_hold");
    push_exp(2, 4'b0000, 4'b0000, 4'b0000, "sync_c4");
    step(1'b0, 4'b1111, 4'b0000, 4'b1111);
    push_exp(2, 4'b1111, 4'b1111, 4'b0000, "sync_rise");
    step(1'b0, 4'b1111, 4'b0000, 4'b1111);
    push_exp(2, 4'b1111, 4'b0000, 4'b0000, "sync_hold");

    // Channels 0..2 fall together; channel 3 stays high.
    step(1'b0, 4'b1000, 4'b0000, 4'b1111);
    push_exp(0, 4'b1111, 4'b0000, 4'b0000, "fall_c1");
    step(1'b0, 4'b1000, 4'b0000, 4'b1111);
    push_exp(0, 4'b1111, 4'b0000, 4'b0000, "fall_c2");
    step(1'b0, 4'b1000, 4'b0000, 4'b1111);
    push_exp(0, 4'b1000, 4'b0000, 4'b0111, "fall_acc");
    step(1'b0, 4'b1000, 4'b0000, 4'b1111);
    push_exp(0, 4'b1000, 4'b0000, 4'b0000, "fall_hold");

    // Glitch train 1,1,0,1,1,0 on channel 0 never qualifies.
    gl = 6'b011011;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, {3'b100, gl[k]}, 4'b0000, 4'b1111);
      push_exp(0, 4'b1000, 4'b0000, 4'b0000, "glitch");
    end
    // Then three highs qualify.
    step(1'b0, 4'b1001, 4'b0000, 4'b1111);
    push_exp(0, 4'b1000, 4'b0000, 4'b0000, "press_c1");
    step(1'b0, 4'b1001, 4'b0000, 4'b1111);
    push_exp(0, 4'b1000, 4'b0000, 4'b0000, "press_c2");
    step(1'b0, 4'b1001, 4'b0000, 4'b1111);
    push_exp(0, 4'b1001, 4'b0001, 4'b0000, "press_acc");
    step(1'b0, 4'b1001, 4'b0000, 4'b1111);
    push_exp(0, 4'b1001, 4'b0000, 4'b0000, "press_hold");

    // Channel 2 rises and channel 3 falls on the same edge.
    step(1'b0, 4'b0101, 4'b0000, 4'b1111);
    push_exp(0, 4'b1001, 4'b0000, 4'b0000, "simul_c1");
    step(1'b0, 4'b0101, 4'b0000, 4'b1111);
    push_exp(0, 4'b1001, 4'b0000, 4'b0000, "simul_c2");
    step(1'b0, 4'b0101, 4'b0000, 4'b1111);
    push_exp(0, 4'b0101, 4'b0100, 4'b1000, "simul_acc");
    step(1'b0, 4'b0101, 4'b0000, 4'b1111);
    push_exp(0, 4'b0101, 4'b0000, 4'b0000, "simul_hold");

    // Reset mid-count discards the partial count.
    step(1'b1, 4'b0000, 4'b0000, 4'b1111);
    push_exp(0, 4'b0000, 4'b0000, 4'b0000, "rstm_clr");
    step(1'b0, 4'b0000, 4'b0000, 4'b1111);
    push_exp(0, 4'b0000, 4'b0000, 4'b0000, "rstm_idle");
    repeat (2) begin
      step(1'b0, 4'b0001, 4'b0000, 4'b1111);
      push_exp(0, 4'b0000, 4'b0000, 4'b0000, "rstm_pre");
    end
    step(1'b1, 4'b0001, 4'b0000, 4'b1111);
    push_exp(0, 4'b0000, 4'b0000, 4'b0000, "rstm_rst");
    repeat (2) begin
      step(1'b0, 4'b0001, 4'b0000, 4'b1111);
      push_exp(0, 4'b0000, 4'b0000, 4'b0000, "rstm_post");
    end
    step(1'b0, 4'b0001, 4'b0000, 4'b1111);
    push_exp(0, 4'b0001, 4'b0001, 4'b0000, "rstm_acc");
    step(1'b0, 4'b0001, 4'b0000, 4'b1111);
    push_exp(0, 4'b0001, 4'b0000, 4'b0000, "rstm_hold");

    // Fast-attack: b[1] rises 5 time units before an edge and is taken at once.
    @(negedge clk);
    #25;
    b1 = 4'b0010;
    push_exp(1, 4'b0010, 4'b0010, 4'b0000, "fa_rise");
    // Bounce between edges; sampled pattern 0,1,0,1 must not drop s[1].
    pat = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #5;
      v = pat[k];
      push_exp(1, 4'b0010, 4'b0000, 4'b0000, "fa_bounce");
      #10 b1[1] = ~v;
      #10 b1[1] = v;
      #10 b1[1] = ~v;
      #10 b1[1] = v;
    end
    // Qualified fall after three low edges.
    @(posedge clk);
    #5;
    b1 = 4'b0000;
    push_exp(1, 4'b0010, 4'b0000, 4'b0000, "fa_low1");
    @(posedge clk);
    #5;
    push_exp(1, 4'b0010, 4'b0000, 4'b0000, "fa_low2");
    @(posedge clk);
    #5;
    push_exp(1, 4'b0000, 4'b0000, 4'b0010, "fa_fall");
    @(posedge clk);
    #5;
    push_exp(1, 4'b0000, 4'b0000, 4'b0000, "fa_fall_hold");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
